// File: rtl/md_ctrl.sv
// Multiply/divide controller: runs fixed-latency mult/div sequences for the E stage,
// owns HI/LO and requests a pipeline stall while a sequence is in flight.
module md_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [3:0]  e_md_op_i,
    input  logic [31:0] e_md_a_i,
    input  logic [31:0] e_md_b_i,
    input  logic        d_md_use_i,
    output logic        md_busy_o,
    output logic        md_stall_o,
    output logic [31:0] md_out_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;
    logic [31:0]        pend_hi_q, pend_hi_d;
    logic [31:0]        pend_lo_q, pend_lo_d;
    logic               pend_we_q, pend_we_d;

    logic               is_mul_op;
    logic               is_div_op;
    logic               is_signed_op;
    logic               start;

    logic [63:0]        mul_a;
    logic [63:0]        mul_b;
    logic [63:0]        product;

    logic               neg_a;
    logic               neg_b;
    logic               div_zero;
    logic [31:0]        mag_a;
    logic [31:0]        mag_b;
    logic [31:0]        mag_b_safe;
    logic [31:0]        mag_quot;
    logic [31:0]        mag_rem;
    logic [31:0]        quotient;
    logic [31:0]        remainder;

    assign is_mul_op    = (e_md_op_i == OP_MULT) || (e_md_op_i == OP_MULTU);
    assign is_div_op    = (e_md_op_i == OP_DIV)  || (e_md_op_i == OP_DIVU);
    assign is_signed_op = (e_md_op_i == OP_MULT) || (e_md_op_i == OP_DIV);
    assign start        = (is_mul_op || is_div_op) && (state_q == IDLE);

    // Sign-extending both operands to 64 bits lets one unsigned multiplier serve mult and multu.
    assign mul_a   = {{32{is_signed_op & e_md_a_i[31]}}, e_md_a_i};
    assign mul_b   = {{32{is_signed_op & e_md_b_i[31]}}, e_md_b_i};
    assign product = mul_a * mul_b;

    assign neg_a      = is_signed_op & e_md_a_i[31];
    assign neg_b      = is_signed_op & e_md_b_i[31];
    assign div_zero   = (e_md_b_i == 32'd0);
    assign mag_a      = neg_a ? (32'd0 - e_md_a_i) : e_md_a_i;
    assign mag_b      = neg_b ? (32'd0 - e_md_b_i) : e_md_b_i;
    assign mag_b_safe = div_zero ? 32'd1 : mag_b;
    assign mag_quot   = mag_a / mag_b_safe;
    assign mag_rem    = mag_a % mag_b_safe;

    // Quotient truncates toward zero; remainder takes the sign of the dividend.
    assign quotient  = (neg_a ^ neg_b) ? (32'd0 - mag_quot) : mag_quot;
    assign remainder = neg_a ? (32'd0 - mag_rem) : mag_rem;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_we_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_we_q <= pend_we_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_we_d = pend_we_q;

        unique case (state_q)
            IDLE: begin
                if (start && is_mul_op) begin
                    pend_hi_d = product[63:32];
                    pend_lo_d = product[31:0];
                    pend_we_d = 1'b1;
                    cnt_d     = CNT_W'(MULT_CYCLES - 1);
                    state_d   = MUL;
                end else if (start) begin
                    pend_hi_d = remainder;
                    pend_lo_d = quotient;
                    pend_we_d = ~div_zero;
                    cnt_d     = CNT_W'(DIV_CYCLES - 1);
                    state_d   = DIV;
                end else if (e_md_op_i == OP_MTHI) begin
                    hi_d = e_md_a_i;
                end else if (e_md_op_i == OP_MTLO) begin
                    lo_d = e_md_a_i;
                end
            end
            MUL, DIV: begin
                // New MDU ops arriving here are dropped; the D-stage stall keeps them out.
                if (cnt_q == '0) begin
                    if (pend_we_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        md_out_o = 32'd0;
        if (e_md_op_i == OP_MFHI) begin
            md_out_o = hi_q;
        end else if (e_md_op_i == OP_MFLO) begin
            md_out_o = lo_q;
        end
    end

    assign md_busy_o  = (state_q != IDLE);
    assign md_stall_o = d_md_use_i & (md_busy_o | start);
    assign hi_o       = hi_q;
    assign lo_o       = lo_q;

endmodule

// File: doc/md_ctrl.md
# md_ctrl

Multiply/divide controller for the five-stage pipeline. Accepts MDU ops from the E stage, runs fixed-latency multiply and divide sequences, and owns the HI/LO registers. While a sequence is in flight it raises a stall request so the D stage cannot issue another MDU instruction.

## Interface
- MULT_CYCLES, 5, busy cycles per mult/multu (≥1)
- DIV_CYCLES, 10, busy cycles per div/divu (≥1)

- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- E_MD_OP  in  4  E-stage op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9–15 treated as none
- E_MD_A  in  32  forwarded rs value
- E_MD_B  in  32  forwarded rt value
- D_MD_USE  in  1  D-stage instruction is any MDU op (1–8)
- MD_BUSY  out  1  sequence in flight
- MD_STALL  out  1  stall request to PC/D_REG, bubble into E_REG
- MD_O  out  32  mfhi/mflo read data for E-stage result mux
- HI  out  32  HI register
- LO  out  32  LO register

## Operation
- States: IDLE, MUL, DIV; down-counter CNT sized for max(MULT_CYCLES, DIV_CYCLES).
- START = (E_MD_OP in 1..4) & state==IDLE; combinational.
- IDLE + START: latch pending result from E_MD_A/E_MD_B; load CNT = MULT_CYCLES-1 (MUL) or DIV_CYCLES-1 (DIV); go to MUL/DIV.
- mult: signed 32×32→64, {HI,LO} = product. multu: unsigned.
- div: LO = signed quotient (truncated toward zero), HI = remainder (sign of dividend). divu: unsigned.
- Divide by zero: full DIV_CYCLES busy sequence, HI/LO unchanged at commit.
- MUL/DIV: CNT decrements each cycle; on edge with CNT==0, commit pending result to HI/LO, return to IDLE.
- mthi/mtlo in IDLE: HI or LO ← E_MD_A at edge. In MUL/DIV: ignored (pipeline stall prevents this; no error).
- MDU op 1–4 arriving while busy: ignored, no restart.
- MD_O = HI when op 5, LO when op 6, else 0; combinational from current registers.
- MD_BUSY = (state != IDLE).
- MD_STALL = D_MD_USE & (MD_BUSY | START). Non-MDU instructions are never stalled.
- Reset (reset=0, any time incl. mid-sequence): state IDLE, CNT 0, HI 0, LO 0, pending result discarded; outputs MD_BUSY 0, MD_STALL 0, MD_O 0 (given E_MD_OP 0), HI 0, LO 0.

## Timing
- Start sampled at edge T. MD_BUSY high cycles T..T+N-1 (N = MULT_CYCLES or DIV_CYCLES); HI/LO new values visible after edge T+N; MD_BUSY low same cycle.
- MD_STALL high in cycle before T if D holds MDU op (START term), and throughout busy window; drops in cycle HI/LO become valid, so a following mfhi reaches E with the committed value.
- Back-to-back: new start allowed in first IDLE cycle (edge T+N); no dead cycle.
- mthi/mtlo: 1-cycle, value visible after the sampling edge.
- Reset is asynchronous assert; deassertion is synchronized externally; first start accepted on first edge with reset=1.

## Test plan
- mult A=0xFFFFFFFF, B=0x00000002 → MD_BUSY 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE; multu same operands → HI=0x00000001, LO=0xFFFFFFFE.
- div A=0xFFFFFFF9 (−7), B=2 → MD_BUSY 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu A=7, B=2 → LO=3, HI=1.
- div with B=0 after HI=0x11111111, LO=0x22222222 set via mthi/mtlo → 10 busy cycles, HI/LO unchanged.
- mult in E with D_MD_USE=1 (mfhi) → MD_STALL high in start cycle and 5 busy cycles, low on cycle 6; MD_O then returns new HI; D_MD_USE=0 during busy → MD_STALL 0.
- reset=0 at busy cycle 3 of div → MD_BUSY, HI, LO 0 immediately (no clock edge needed); after release, mult 3×4 → LO=12, HI=0 after 5 cycles.
- Second div issued while busy (forced, stall ignored) → ignored; first result committed at original edge, MD_BUSY drops on schedule.
